// File: rtl/uart_rx_packer.sv
// UART receiver that deserialises N_WORDS frames into one wide bus and
// presents it on a valid/ready handshake. Configurable parity and stop bits.
// Reports framing, parity and overflow errors. A partial bus is discarded
// when the line stays idle too long between frames.
module uart_rx_packer #(
    parameter int CLOCKS_PER_PULSE = 2604,
    parameter int BITS_PER_WORD    = 8,
    parameter int N_WORDS          = 3,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int GAP_TIMEOUT      = 0
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               rx,
    output logic [N_WORDS*BITS_PER_WORD-1:0]   m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               overflow
);

    localparam int BUS_W = N_WORDS * BITS_PER_WORD;
    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W = $clog2(BITS_PER_WORD + 1);
    localparam int IDX_W = $clog2(N_WORDS + 1);
    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'((GAP_TIMEOUT > 0) ? GAP_TIMEOUT : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                     state_reg;
    logic                       rx_meta_reg;
    logic                       rx_s_reg;
    logic [CNT_W-1:0]           clk_cnt_reg;
    logic [BIT_W-1:0]           bit_cnt_reg;
    logic [BITS_PER_WORD-1:0]   shift_reg;
    logic                       parity_bad_reg;
    logic                       stop_bad_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [GAP_W-1:0]           gap_cnt_reg;
    logic [BUS_W-1:0]           asm_buf_reg;
    logic [BUS_W-1:0]           m_data_reg;
    logic                       m_valid_reg;
    logic                       frame_err_reg;
    logic                       parity_err_reg;
    logic                       overflow_reg;

    logic [BUS_W-1:0]           bus_next;
    logic                       parity_exp;

    // Expected parity bit over the received data bits (even or odd).
    assign parity_exp = (PARITY == 2) ? ~(^shift_reg) : ^shift_reg;

    // Assembly buffer with the word just received dropped into its slot.
    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : g_slot
            assign bus_next[gi*BITS_PER_WORD +: BITS_PER_WORD] =
                (idx_reg == IDX_W'(gi)) ? shift_reg
                                        : asm_buf_reg[gi*BITS_PER_WORD +: BITS_PER_WORD];
        end
    endgenerate

    assign m_data     = m_data_reg;
    assign m_valid    = m_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overflow   = overflow_reg;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Frame FSM, word packing, bus handoff and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_IDLE;
            clk_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_bad_reg <= 1'b0;
            stop_bad_reg   <= 1'b0;
            idx_reg        <= '0;
            gap_cnt_reg    <= '0;
            asm_buf_reg    <= '0;
            m_data_reg     <= '0;
            m_valid_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    clk_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                    if (!rx_s_reg) begin
                        state_reg   <= S_START;
                        gap_cnt_reg <= '0;
                    end else if ((GAP_TIMEOUT > 0) && (idx_reg != '0)) begin
                        if (gap_cnt_reg == GAP_LIMIT) begin
                            idx_reg     <= '0;
                            gap_cnt_reg <= '0;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                end

                S_START: begin
                    if (clk_cnt_reg == HALF_CNT) begin
                        clk_cnt_reg <= '0;
                        // A line already back high mid-bit is noise, not a frame.
                        state_reg   <= rx_s_reg ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                S_DATA: begin
                    if (clk_cnt_reg == FULL_CNT) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_s_reg, shift_reg[BITS_PER_WORD-1:1]};
                        if (bit_cnt_reg == LAST_DATA) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (clk_cnt_reg == FULL_CNT) begin
                        clk_cnt_reg    <= '0;
                        parity_bad_reg <= (rx_s_reg != parity_exp);
                        state_reg      <= S_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                S_STOP: begin
                    if (clk_cnt_reg == FULL_CNT) begin
                        clk_cnt_reg <= '0;
                        if (bit_cnt_reg != LAST_STOP) begin
                            stop_bad_reg <= stop_bad_reg | ~rx_s_reg;
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        end else begin
                            state_reg      <= S_IDLE;
                            bit_cnt_reg    <= '0;
                            stop_bad_reg   <= 1'b0;
                            parity_bad_reg <= 1'b0;
                            // Framing outranks parity; either drops the partial bus.
                            if (stop_bad_reg || !rx_s_reg) begin
                                frame_err_reg <= 1'b1;
                                idx_reg       <= '0;
                            end else if (parity_bad_reg) begin
                                parity_err_reg <= 1'b1;
                                idx_reg        <= '0;
                            end else if (idx_reg == LAST_IDX) begin
                                idx_reg <= '0;
                                if (!m_valid_reg || m_ready) begin
                                    m_data_reg  <= bus_next;
                                    m_valid_reg <= 1'b1;
                                end else begin
                                    overflow_reg <= 1'b1;
                                end
                            end else begin
                                asm_buf_reg <= bus_next;
                                idx_reg     <= idx_reg + 1'b1;
                            end
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: 8-bit words, even parity, two stop
// bits, 8 clocks per bit, 3 words per bus, gap timeout of 100 cycles.
module tb_uart_rx_packer;

    localparam int CPP = 8;

    logic        clk;
    logic        rstn;
    logic        rx;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;
    logic        parity_err;
    logic        overflow;

    int cmp_cnt = 0;
    int err_cnt = 0;

    int          xfer_cnt  = 0;
    int          valid_cyc = 0;
    int          fe_cnt    = 0;
    int          pe_cnt    = 0;
    int          ov_cnt    = 0;
    logic [23:0] last_data = '0;

    uart_rx_packer #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (8),
        .N_WORDS          (3),
        .PARITY           (1),
        .STOP_BITS        (2),
        .GAP_TIMEOUT      (100)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (m_valid) valid_cyc++;
            if (m_valid && m_ready) begin
                xfer_cnt++;
                last_data = m_data;
            end
            if (frame_err)  fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overflow)   ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_counts();
        xfer_cnt  = 0;
        valid_cyc = 0;
        fe_cnt    = 0;
        pe_cnt    = 0;
        ov_cnt    = 0;
        last_data = '0;
    endtask

    // Called at posedge+1; holds one bit for CPP clocks.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    // One frame: start, 8 data LSB-first, even parity, 2 stop bits, 1 idle bit.
    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = (^b) ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(~bad_stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    initial begin
        rstn    = 1'b0;
        rx      = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", {31'b0, m_valid}, 32'h0);
        check("rst_m_data", {8'b0, m_data}, 32'h0);
        check("rst_errs", {29'b0, frame_err, parity_err, overflow}, 32'h0);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Basic three-word bus with downstream always ready.
        clear_counts();
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        check("basic_xfer", xfer_cnt, 1);
        check("basic_data", {8'b0, last_data}, 32'h01C35A);
        check("basic_valid_cycles", valid_cyc, 1);
        check("basic_no_err", fe_cnt + pe_cnt + ov_cnt, 0);

        // Parity error discards the partial bus.
        clear_counts();
        send_byte(8'h99, 1'b0, 1'b0);
        send_byte(8'h07, 1'b1, 1'b0);
        check("par_err_pulse", pe_cnt, 1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        check("par_xfer", xfer_cnt, 1);
        check("par_data", {8'b0, last_data}, 32'h332211);
        check("par_no_fe", fe_cnt, 0);

        // Back-pressure: second bus dropped, first held.
        clear_counts();
        m_ready = 1'b0;
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        check("ovf_held_valid", {31'b0, m_valid}, 32'h1);
        check("ovf_held_data", {8'b0, m_data}, 32'h030201);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        check("ovf_pulse", ov_cnt, 1);
        check("ovf_data_stable", {8'b0, m_data}, 32'h030201);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovf_xfer", xfer_cnt, 1);
        check("ovf_xfer_data", {8'b0, last_data}, 32'h030201);
        check("ovf_valid_drop", {31'b0, m_valid}, 32'h0);

        // Framing error on the second word.
        clear_counts();
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        check("fe_pulse", fe_cnt, 1);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        check("fe_xfer", xfer_cnt, 1);
        check("fe_data", {8'b0, last_data}, 32'hCCBBAA);
        check("fe_no_pe", pe_cnt, 0);

        // Short low glitch is rejected as a false start.
        clear_counts();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_quiet", valid_cyc + fe_cnt + pe_cnt + ov_cnt, 0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        check("glitch_after_data", {8'b0, last_data}, 32'h563412);

        // Gap timeout drops two orphan words.
        clear_counts();
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'hE2, 1'b0, 1'b0);
        repeat (150) @(posedge clk);
        #1;
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h30, 1'b0, 1'b0);
        check("gap_xfer", xfer_cnt, 1);
        check("gap_data", {8'b0, last_data}, 32'h302010);

        // Asynchronous reset mid-frame with a bus held.
        m_ready = 1'b0;
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        send_byte(8'h99, 1'b0, 1'b0);
        check("rst_pre_valid", {31'b0, m_valid}, 32'h1);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, m_valid}, 32'h0);
        check("rst_mid_data", {8'b0, m_data}, 32'h0);
        check("rst_mid_errs", {29'b0, frame_err, parity_err, overflow}, 32'h0);
        rx      = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_counts();
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'h0A, 1'b0, 1'b0);
        send_byte(8'h0B, 1'b0, 1'b0);
        send_byte(8'h0C, 1'b0, 1'b0);
        check("post_rst_xfer", xfer_cnt, 1);
        check("post_rst_data", {8'b0, last_data}, 32'h0C0B0A);
        check("post_rst_no_err", fe_cnt + pe_cnt + ov_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_packer.md
Name: uart_rx_packer

Overview:
Parametrised UART receiver with word-to-bus packer, the successor to the fixed 8N1 receive path feeding the MVM core. It deserialises N_WORDS UART frames into one wide bus and presents the bus on a valid/ready handshake. Over the fixed receiver it adds:
- configurable parity and stop bits,
- false-start rejection,
- framing, parity and overflow reporting,
- an inter-word gap timeout that resynchronises partially assembled buses.

Parameters:
CLOCKS_PER_PULSE, 2604, clk cycles per UART bit (>=4)
BITS_PER_WORD, 8, data bits per frame (5..9)
N_WORDS, 3, frames packed per output bus (>=1)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
GAP_TIMEOUT, 0, idle clk cycles between frames of one bus before the partial bus is discarded; 0 disables

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
rx  in  1  UART serial input, idle high, asynchronous to clk
m_data  out  N_WORDS*BITS_PER_WORD  packed bus; word i at bits [i*BITS_PER_WORD +: BITS_PER_WORD]; word 0 = first received, LSB-first within each word
m_valid  out  1  m_data is valid
m_ready  in  1  downstream accepts m_data
frame_err  out  1  1-cycle pulse: stop bit sampled 0
parity_err  out  1  1-cycle pulse: parity mismatch
overflow  out  1  1-cycle pulse: completed bus dropped

Behaviour:
- Reset:
  - All outputs 0; m_data 0.
  - FSM goes to IDLE; word index 0; all counters 0.
  - The rx synchroniser resets to 1.
- rx passes through a 2-flop synchroniser (rx_s). All timing below is relative to rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s==0 -> START, bit counter cleared.
  - START: after CLOCKS_PER_PULSE/2 cycles, sample rx_s. If 1 it is a false start: -> IDLE, no error. If 0 -> DATA.
  - DATA: sample every CLOCKS_PER_PULSE cycles. BITS_PER_WORD samples, LSB first. Then -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: one sample; the expected value is the even/odd parity over the data bits. -> STOP.
  - STOP: STOP_BITS samples at CLOCKS_PER_PULSE spacing. After the last one -> IDLE.
- Word completion happens at the final stop-bit sample:
  - Any stop sample 0: frame_err pulses next cycle; the word is discarded; word index resets to 0.
  - Else parity bad: parity_err pulses next cycle; the word is discarded; word index resets to 0.
  - If both apply, only frame_err pulses.
  - Else: the word is written to the assembly buffer slot [index] and the index increments.
- Bus completion (index reaches N_WORDS):
  - If the output is free, or m_valid && m_ready in the same cycle: m_data <= assembly buffer and m_valid=1 on the clock edge after the final stop sample.
  - If m_valid=1 and m_ready=0: the new bus is dropped, overflow pulses once, and the held m_data is unchanged.
  - In both cases the index returns to 0.
- Handshake:
  - m_valid stays high and m_data stays stable until a cycle with m_ready=1.
  - m_valid falls the next cycle unless a new bus lands in that same cycle, in which case it stays high with new data.
  - Reception never stalls on m_ready.
- Gap timeout (GAP_TIMEOUT>0): a counter runs in IDLE while 0<index<N_WORDS. When it reaches GAP_TIMEOUT, index resets to 0 silently. The counter clears on a start edge.
- Asserting rstn low at any time, including mid-frame or with m_valid high, applies the reset values immediately. The first frame after release requires a fresh falling edge.

Test Plan:
- Defaults with CLOCKS_PER_PULSE=8, N_WORDS=3. Send 8N1 bytes 0x5A, 0xC3, 0x01 with m_ready=1 -> m_data=0x01C35A; m_valid high for exactly 1 cycle, 1 clk after the third stop sample.
- PARITY=1, STOP_BITS=2. Send 0x07 with parity bit 0 (expected 1) -> parity_err pulse, index reset. Next 3 good bytes 0x11, 0x22, 0x33 -> m_data=0x332211.
- Hold m_ready=0 and send 6 bytes 0x01..0x06 -> first bus 0x030201 held stable; overflow pulse once at 6th stop; raising m_ready then gives one transfer of 0x030201.
- Stop bit forced 0 on the 2nd byte -> frame_err; the following 3 bytes 0xAA, 0xBB, 0xCC -> m_data=0xCCBBAA.
- rx low glitch of 3 cycles (less than CLOCKS_PER_PULSE/2) -> no state change, no error, no m_valid.
- GAP_TIMEOUT=100. Send 2 bytes, idle 150 cycles, then 3 bytes 0x10, 0x20, 0x30 -> m_data=0x302010. Assert rstn low mid-byte -> all outputs 0 immediately.
